alu_regfile: RTL and testbench

- Register file directly upstream of the ALU; supplies its A and B operands.
- 32 x 32-bit registers, two synchronous read ports, one synchronous write port.
- Read data is registered, so operands appear one cycle after the read request.
- Write-to-read bypass and register 0 hardwired to zero.

---
 rtl/alu_regfile_pkg.sv | 23 ++
 rtl/alu_regfile_if.sv | 20 ++
 rtl/alu_regfile_read_port.sv | 32 +++
 rtl/alu_regfile.sv | 34 +++
 tb/tb_alu_regfile.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/alu_regfile_pkg.sv
// alu_regfile_pkg: widths, register-0 constant and ALU op encodings shared by the register file and the ALU
package alu_regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;
    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_OR  = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd6,
        OP_SLT = 4'd7,
        OP_NOR = 4'd12
    } alu_op_e;
    // Reference ALU result for the operands this register file supplies.
    function automatic logic [DEF_DATA_W-1:0] alu_calc(alu_op_e op, logic [DEF_DATA_W-1:0] a, logic [DEF_DATA_W-1:0] b);
        return op == OP_AND ? a & b :
               op == OP_OR  ? a | b :
               op == OP_ADD ? a + b :
               op == OP_SUB ? a - b :
               op == OP_SLT ? {{(DEF_DATA_W-1){1'b0}}, $signed(a) < $signed(b)} :
               op == OP_NOR ? ~(a | b) : '0;
    endfunction
endpackage

// File: rtl/alu_regfile_if.sv
// alu_regfile_if: read/write bus between the datapath (master) and the register file (slave)
//   Rd_en/Ard1/Ard2 read request, Wr_en/Awr/Din write, Dout1/Dout2/Rd_valid registered read result
interface alu_regfile_if
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              Rd_en;
    logic [ADDR_W-1:0] Ard1;
    logic [ADDR_W-1:0] Ard2;
    logic              Wr_en;
    logic [ADDR_W-1:0] Awr;
    logic [DATA_W-1:0] Din;
    logic [DATA_W-1:0] Dout1;
    logic [DATA_W-1:0] Dout2;
    logic              Rd_valid;
    modport master (output Rd_en, Ard1, Ard2, Wr_en, Awr, Din, input Dout1, Dout2, Rd_valid);
    modport slave  (input Rd_en, Ard1, Ard2, Wr_en, Awr, Din, output Dout1, Dout2, Rd_valid);
endinterface

// File: rtl/alu_regfile_read_port.sv
// alu_regfile_read_port: one registered read port with register-0 forcing and optional write bypass
//   clk/rst_n clock and async active-low reset, rd_en_i/addr_i read request,
//   wr_en_i/awr_i/din_i same-edge write for bypass, mem_i storage array, dout_o registered data
module alu_regfile_read_port
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] awr_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
    output logic [DATA_W-1:0] dout_o
);
    logic [DATA_W-1:0] dout_d, dout_q;
    logic              hit;
    // Register 0 is checked first so a same-edge write to it can never be forwarded.
    assign hit = BYPASS && wr_en_i && (awr_i == addr_i);
    always_comb dout_d = !rd_en_i ? dout_q :
                         (addr_i == ADDR_W'(ZERO_REG)) ? '0 :
                         hit ? din_i : mem_i[addr_i];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
    assign dout_o = dout_q;
endmodule

// File: rtl/alu_regfile.sv
// alu_regfile: 2R1W register file feeding ALU A/B with registered reads, write bypass and hardwired r0
//   clk/rst_n clock and async active-low reset; bus (slave) carries read/write requests and read data
module alu_regfile
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    alu_regfile_if.slave bus
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic              rd_valid_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.Rd_en;
            if (bus.Wr_en && bus.Awr != ADDR_W'(ZERO_REG)) mem_q[bus.Awr] <= bus.Din;
        end
    end
    alu_regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rp1 (
        .clk(clk), .rst_n(rst_n), .rd_en_i(bus.Rd_en), .addr_i(bus.Ard1),
        .wr_en_i(bus.Wr_en), .awr_i(bus.Awr), .din_i(bus.Din), .mem_i(mem_q), .dout_o(bus.Dout1)
    );
    alu_regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rp2 (
        .clk(clk), .rst_n(rst_n), .rd_en_i(bus.Rd_en), .addr_i(bus.Ard2),
        .wr_en_i(bus.Wr_en), .awr_i(bus.Awr), .din_i(bus.Din), .mem_i(mem_q), .dout_o(bus.Dout2)
    );
    assign bus.Rd_valid = rd_valid_q;
endmodule

// File: tb/tb_alu_regfile.sv
// tb_alu_regfile: directed checks of a bypassing and a non-bypassing register file driven in lockstep
module tb_alu_regfile;
    import alu_regfile_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    alu_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    alu_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    assign bus0.Rd_en = bus1.Rd_en;
    assign bus0.Ard1  = bus1.Ard1;
    assign bus0.Ard2  = bus1.Ard2;
    assign bus0.Wr_en = bus1.Wr_en;
    assign bus0.Awr   = bus1.Awr;
    assign bus0.Din   = bus1.Din;
    alu_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic [4:0] a1, input logic [4:0] a2,
                         input logic wr, input logic [4:0] aw, input logic [31:0] d);
        bus1.Rd_en = rd; bus1.Ard1 = a1; bus1.Ard2 = a2;
        bus1.Wr_en = wr; bus1.Awr = aw; bus1.Din = d;
    endtask

    task automatic chk_both(input string tag, input logic [31:0] e1, input logic [31:0] e2, input logic ev);
        chk({tag, "_b1_dout1"}, bus1.Dout1, e1);
        chk({tag, "_b1_dout2"}, bus1.Dout2, e2);
        chk({tag, "_b1_valid"}, {31'd0, bus1.Rd_valid}, {31'd0, ev});
        chk({tag, "_b0_dout1"}, bus0.Dout1, e1);
        chk({tag, "_b0_dout2"}, bus0.Dout2, e2);
        chk({tag, "_b0_valid"}, {31'd0, bus0.Rd_valid}, {31'd0, ev});
    endtask

    initial begin
        logic [31:0] sum;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        // reset asserted between edges, outputs clear without a clock edge
        #3 rst_n = 1'b0;
        #1 chk_both("rst_async", 32'd0, 32'd0, 1'b0);
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 32'hFFFF_FFFF);
        tick;
        chk_both("rst_hold", 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        #2 rst_n = 1'b1;
        tick;
        chk_both("rst_release", 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'd0);
            tick;
            chk_both($sformatf("rst_read%0d", i), 32'd0, 32'd0, 1'b1);
        end
        // basic write then read, operands into the ALU
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 32'd1);
        tick;
        chk_both("wr_idle", 32'd0, 32'd0, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 32'd2);
        tick;
        drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0);
        tick;
        chk_both("rd12", 32'd1, 32'd2, 1'b1);
        sum = alu_calc(OP_ADD, bus1.Dout1, bus1.Dout2);
        chk("alu_add", sum, 32'd3);
        chk("alu_zero", {31'd0, sum == 32'd0}, 32'd0);
        // register 0 ignores writes
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        tick;
        drive(1'b1, 5'd0, 5'd1, 1'b0, 5'd0, 32'd0);
        tick;
        chk_both("r0_read", 32'd0, 32'd1, 1'b1);
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        tick;
        chk_both("r0_collide", 32'd0, 32'd0, 1'b1);
        // same-edge write/read collision on both ports
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'd11);
        tick;
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 32'd20);
        tick;
        chk("byp1_dout1", bus1.Dout1, 32'd20);
        chk("byp1_dout2", bus1.Dout2, 32'd20);
        chk("byp0_dout1", bus0.Dout1, 32'd11);
        chk("byp0_dout2", bus0.Dout2, 32'd11);
        drive(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
        tick;
        chk_both("byp_reread", 32'd20, 32'd20, 1'b1);
        // one port colliding, the other reading a different register
        drive(1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 32'h0000_0077);
        tick;
        chk("byp1_port1", bus1.Dout1, 32'h77);
        chk("byp1_port2", bus1.Dout2, 32'd1);
        chk("byp0_port1", bus0.Dout1, 32'd0);
        chk("byp0_port2", bus0.Dout2, 32'd1);
        // Rd_en 1,1,0,1 and hold
        drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0);
        tick;
        chk_both("hold_a", 32'd1, 32'd2, 1'b1);
        drive(1'b1, 5'd5, 5'd1, 1'b0, 5'd0, 32'd0);
        tick;
        chk_both("hold_b", 32'd20, 32'd1, 1'b1);
        drive(1'b0, 5'd2, 5'd7, 1'b0, 5'd0, 32'd0);
        tick;
        chk_both("hold_c", 32'd20, 32'd1, 1'b0);
        drive(1'b1, 5'd2, 5'd5, 1'b0, 5'd0, 32'd0);
        tick;
        chk_both("hold_d", 32'd2, 32'd20, 1'b1);
        // all-ones data through r31
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd31, 32'hFFFF_FFFF);
        tick;
        drive(1'b1, 5'd31, 5'd0, 1'b0, 5'd0, 32'd0);
        tick;
        chk_both("r31", 32'hFFFF_FFFF, 32'd0, 1'b1);
        // async reset during back-to-back writes
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 32'd33);
        tick;
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 32'd44);
        tick;
        chk_both("pre_rst", 32'd1, 32'd2, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk_both("mid_rst", 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 1; i < 32; i += 2) begin
            drive(1'b1, 5'(i), 5'(i + 1), 1'b0, 5'd0, 32'd0);
            tick;
            chk_both($sformatf("post_rst%0d", i), 32'd0, 32'd0, 1'b1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
